// File: rtl/cdbus_csr_arb_if.sv
// rtl/cdbus_csr_arb_if.sv - requester and cdbus CSR signal bundle for cdbus_csr_arb
// Purpose: groups the host requester handshake and the cdbus CSR port in one interface.
// Signals:
//   req_read/req_write/req_addr/req_wdata - per-requester request, packed by index
//   req_lock                              - per-requester grant lock (CD_ARB_LOCK_EN only)
//   req_ack/req_rdata                     - one-cycle completion pulse and read data
//   chip_select/csr_*                     - single-cycle access to the cdbus node
// Modports: master = arbiter side, slave = requesters plus cdbus node.
interface cdbus_csr_arb_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req_read;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
`ifdef CD_ARB_LOCK_EN
  logic [NREQ-1:0]        req_lock;
`endif
  logic [NREQ-1:0]        req_ack;
  logic [DATA_W-1:0]      req_rdata;
  logic                   chip_select;
  logic [ADDR_W-1:0]      csr_address;
  logic                   csr_read;
  logic                   csr_write;
  logic [DATA_W-1:0]      csr_writedata;
  logic [DATA_W-1:0]      csr_readdata;

  modport master (
    input  req_read, req_write, req_addr, req_wdata,
`ifdef CD_ARB_LOCK_EN
    input  req_lock,
`endif
    input  csr_readdata,
    output req_ack, req_rdata,
    output chip_select, csr_address, csr_read, csr_write, csr_writedata
  );

  modport slave (
    output req_read, req_write, req_addr, req_wdata,
`ifdef CD_ARB_LOCK_EN
    output req_lock,
`endif
    output csr_readdata,
    input  req_ack, req_rdata,
    input  chip_select, csr_address, csr_read, csr_write, csr_writedata
  );
endinterface

// File: rtl/cdbus_csr_arb.sv
// rtl/cdbus_csr_arb.sv - round-robin arbiter sharing one cdbus CSR port
// Purpose: serialises NREQ host requesters onto single-cycle cdbus CSR accesses,
//   returning read data and a one-cycle ack to the owning requester.
// Ports:
//   clk   - single clock, shared with the cdbus CSR side
//   reset - asynchronous, active-high
//   bus   - cdbus_csr_arb_if.master (requester handshake and cdbus CSR port)
// Option: define CD_ARB_LOCK_EN to add req_lock, which keeps the grant on the
//   current owner across its ack for atomic read-modify-write sequences.
module cdbus_csr_arb #(
  parameter int NREQ       = 2,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  cdbus_csr_arb_if.master bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int RL_M1 = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  ACK_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;  // also the owner of the access in flight
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]     ack_q, ack_d;
`ifdef CD_ARB_LOCK_EN
  logic                locked_q, locked_d;
`endif

  logic [NREQ-1:0]     pending;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

  // Round-robin pick, scanning upward from the slot after the last grant.
  always_comb begin : rr_pick
    int idx;
    idx        = 0;
    // The requester acked this cycle still shows its old request; mask it.
    pending    = (bus.req_read | bus.req_write) & ~ack_q;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && pending[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
`ifdef CD_ARB_LOCK_EN
    // Cycle after a locked ack: the owner wins if it is still requesting.
    if (locked_q && (bus.req_read[last_grant_q] || bus.req_write[last_grant_q])) begin
      pick_valid = 1'b1;
      pick_idx   = last_grant_q;
    end
    // Locked ack cycle: grant nobody so the owner gets a cycle to re-request.
    if ((|ack_q) && bus.req_lock[last_grant_q]) pick_valid = 1'b0;
`endif
  end

  always_comb begin : fsm_next
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    op_write_d        = op_write_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    rdata_d           = rdata_q;
    cnt_d             = cnt_q;
    ack_d             = '0;
    bus.chip_select   = 1'b0;
    bus.csr_address   = '0;
    bus.csr_read      = 1'b0;
    bus.csr_write     = 1'b0;
    bus.csr_writedata = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          last_grant_d = pick_idx;
          // A requester raising both read and write gets the write.
          op_write_d   = bus.req_write[pick_idx];
          addr_d       = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d      = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        bus.chip_select   = 1'b1;
        bus.csr_address   = addr_q;
        bus.csr_writedata = wdata_q;
        bus.csr_write     = op_write_q;
        bus.csr_read      = !op_write_q;
        if (op_write_q) begin
          ack_d   = ACK_ONE << last_grant_q;
          state_d = IDLE;
        end else if (RD_LATENCY == 0) begin
          rdata_d = bus.csr_readdata;
          ack_d   = ACK_ONE << last_grant_q;
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(RL_M1);
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (cnt_q == '0) begin
          rdata_d = bus.csr_readdata;
          ack_d   = ACK_ONE << last_grant_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CD_ARB_LOCK_EN
  always_comb begin : lock_next
    locked_d = (|ack_q) && bus.req_lock[last_grant_q];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_IDX;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      ack_q        <= '0;
`ifdef CD_ARB_LOCK_EN
      locked_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
`ifdef CD_ARB_LOCK_EN
      locked_q     <= locked_d;
`endif
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.req_rdata = rdata_q;
endmodule

// File: tb/tb_cdbus_csr_arb.sv
// tb/tb_cdbus_csr_arb.sv - bench for cdbus_csr_arb (NREQ=2, ADDR_W=4, DATA_W=32, RD_LATENCY=1)
module tb_cdbus_csr_arb;
  localparam int NREQ = 2;
  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int RDL  = 1;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  cdbus_csr_arb_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  cdbus_csr_arb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Transaction-schedule model: each grant books absolute cycles for its
  // strobe, its read-data sample and its ack.
  int         m_cyc = 0;
  bit         m_busy = 0;
  int         m_own, m_strobe, m_sample, m_ack;
  bit         m_wr;
  logic [3:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  int         m_last = NREQ - 1;
  bit         m_hold = 0;

  always @(negedge clk) begin : compare
    logic [1:0] e_ack;
    logic       e_cs;
    logic [1:0] reqs, pend;
    int         pick;
    bit         new_hold;
    m_cyc++;
    if (reset) begin
      m_busy = 0; m_last = NREQ - 1; m_hold = 0; m_rdata = '0;
      check("m_rst_ack", bus.req_ack, 0);
      check("m_rst_cs", bus.chip_select, 0);
      check("m_rst_rd", bus.csr_read, 0);
      check("m_rst_wr", bus.csr_write, 0);
      check("m_rst_rdata", bus.req_rdata, 0);
    end else begin
      e_cs = m_busy && (m_cyc == m_strobe);
      if (m_busy && !m_wr && m_cyc == m_sample) m_rdata = bus.csr_readdata;
      e_ack = (m_busy && m_cyc == m_ack) ? (2'b01 << m_own) : 2'b00;
      check("m_ack", bus.req_ack, e_ack);
      check("m_cs", bus.chip_select, e_cs);
      check("m_rd", bus.csr_read, e_cs && !m_wr);
      check("m_wr", bus.csr_write, e_cs && m_wr);
      if (e_cs) begin
        check("m_addr", bus.csr_address, m_addr);
        check("m_wdata", bus.csr_writedata, m_wdata);
      end
      if (e_ack != 0 && !m_wr) check("m_rdata", bus.req_rdata, m_rdata);
      if (e_ack != 0) m_busy = 0;
      new_hold = 0;
      if (!m_busy) begin
        reqs = bus.req_read | bus.req_write;
        pend = reqs & ~e_ack;
        pick = -1;
`ifdef CD_ARB_LOCK_EN
        if (e_ack != 0 && bus.req_lock[m_own]) new_hold = 1;
        else if (m_hold && reqs[m_last]) pick = m_last;
`endif
        if (!new_hold && pick < 0)
          for (int k = 1; k <= NREQ; k++)
            if (pick < 0 && pend[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
        if (pick >= 0) begin
          m_busy   = 1;
          m_own    = pick;
          m_last   = pick;
          m_wr     = bus.req_write[pick];
          m_addr   = bus.req_addr[pick*AW +: AW];
          m_wdata  = bus.req_wdata[pick*DW +: DW];
          m_strobe = m_cyc + 1;
          m_sample = m_cyc + 1 + RDL;
          m_ack    = m_wr ? m_cyc + 2 : m_cyc + 2 + RDL;
        end
      end
      m_hold = new_hold;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic neg();  @(negedge clk); endtask

  task automatic set_req(input int i, input logic rd, input logic wr,
                         input logic [3:0] a, input logic [31:0] d);
    bus.req_read[i]          = rd;
    bus.req_write[i]         = wr;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  int ack_log[$];
  int exp6[5];
  int n_ack0;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1;
    bus.req_read = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.csr_readdata = '0;
`ifdef CD_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    neg();
    check("rst_ack", bus.req_ack, 0);
    check("rst_cs", bus.chip_select, 0);
    check("rst_rdata", bus.req_rdata, 0);
    tick(); reset = 1'b0;
    neg();

    // 1: write from requester 1
    tick(); set_req(1, 0, 1, 4'h3, 32'hDEADBEEF); neg();
    tick(); neg();
    check("t1_cs", bus.chip_select, 1);
    check("t1_wr", bus.csr_write, 1);
    check("t1_rd", bus.csr_read, 0);
    check("t1_addr", bus.csr_address, 4'h3);
    check("t1_wdata", bus.csr_writedata, 32'hDEADBEEF);
    tick(); neg();
    check("t1_ack", bus.req_ack, 2'b10);
    tick(); set_req(1, 0, 0, 4'h0, 32'h0); neg();
    check("t1_ack_gone", bus.req_ack, 2'b00);

    // 2: read from requester 0, slave data valid only at t+2
    tick(); set_req(0, 1, 0, 4'h0, 32'h0); bus.csr_readdata = 32'hBAD0BAD0; neg();
    tick(); neg();
    check("t2_cs", bus.chip_select, 1);
    check("t2_rd", bus.csr_read, 1);
    check("t2_wr", bus.csr_write, 0);
    tick(); bus.csr_readdata = 32'h12345678; neg();
    check("t2_wait_cs", bus.chip_select, 0);
    check("t2_wait_ack", bus.req_ack, 2'b00);
    tick(); bus.csr_readdata = 32'hBAD0BAD0; neg();
    check("t2_ack", bus.req_ack, 2'b01);
    check("t2_rdata", bus.req_rdata, 32'h12345678);
    tick(); set_req(0, 0, 0, 4'h0, 32'h0); neg();

    // 3: both requesters stream writes from reset
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    set_req(0, 0, 1, 4'h1, 32'h11110000);
    set_req(1, 0, 1, 4'h2, 32'h22220000);
    ack_log.delete();
    for (int c = 0; c < 9; c++) begin
      neg();
      if (bus.req_ack != 0) ack_log.push_back(bus.req_ack[1] ? 1 : 0);
      tick();
    end
    set_req(0, 0, 0, 4'h0, 32'h0); set_req(1, 0, 0, 4'h0, 32'h0);
    check("t3_nacks", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      check("t3_g0", ack_log[0], 0);
      check("t3_g1", ack_log[1], 1);
      check("t3_g2", ack_log[2], 0);
      check("t3_g3", ack_log[3], 1);
    end
    repeat (4) begin neg(); tick(); end

    // 4: reset during WAIT_RD, then requester 1 read restarts cleanly
    set_req(1, 1, 0, 4'h2, 32'h0); bus.csr_readdata = 32'hA5A50001; neg();
    tick(); neg();
    tick(); #2 reset = 1'b1; neg();
    check("t4_ack", bus.req_ack, 2'b00);
    check("t4_cs", bus.chip_select, 0);
    check("t4_rd", bus.csr_read, 0);
    check("t4_addr", bus.csr_address, 4'h0);
    check("t4_rdata", bus.req_rdata, 32'h0);
    tick(); neg();
    check("t4_noack", bus.req_ack, 2'b00);
    tick(); reset = 1'b0; neg();
    tick(); neg();
    check("t4_re_rd", bus.csr_read, 1);
    check("t4_re_addr", bus.csr_address, 4'h2);
    tick(); neg();
    tick(); neg();
    check("t4_re_ack", bus.req_ack, 2'b10);
    check("t4_re_rdata", bus.req_rdata, 32'hA5A50001);
    tick(); set_req(1, 0, 0, 4'h0, 32'h0); neg();

    // 5: read and write together on requester 0
    n_ack0 = 0;
    tick(); set_req(0, 1, 1, 4'h5, 32'h55AA33CC); neg();
    tick(); neg();
    check("t5_wr", bus.csr_write, 1);
    check("t5_rd", bus.csr_read, 0);
    check("t5_addr", bus.csr_address, 4'h5);
    check("t5_wdata", bus.csr_writedata, 32'h55AA33CC);
    tick(); neg();
    n_ack0 += int'(bus.req_ack[0]);
    tick(); set_req(0, 0, 0, 4'h0, 32'h0); neg();
    n_ack0 += int'(bus.req_ack[0]);
    repeat (4) begin tick(); neg(); n_ack0 += int'(bus.req_ack[0]); end
    check("t5_one_ack", n_ack0, 1);

    // 6: requester 0 does three writes while requester 1 waits
`ifdef CD_ARB_LOCK_EN
    exp6 = '{0, 0, 0, 1, 1};
`else
    exp6 = '{0, 1, 0, 1, 0};
`endif
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    set_req(1, 0, 1, 4'h9, 32'h99990000);
    set_req(0, 0, 1, 4'h8, 32'h88880000);
`ifdef CD_ARB_LOCK_EN
    bus.req_lock[0] = 1'b1;
`endif
    n_ack0 = 0;
    ack_log.delete();
    for (int c = 0; c < 40 && ack_log.size() < 5; c++) begin
      neg();
      if (bus.req_ack != 0) begin
        ack_log.push_back(bus.req_ack[1] ? 1 : 0);
        if (bus.req_ack[0]) n_ack0++;
      end
      tick();
      if (n_ack0 == 3 && bus.req_write[0]) begin
        set_req(0, 0, 0, 4'h0, 32'h0);
`ifdef CD_ARB_LOCK_EN
        bus.req_lock[0] = 1'b0;
`endif
      end
    end
    set_req(0, 0, 0, 4'h0, 32'h0); set_req(1, 0, 0, 4'h0, 32'h0);
    check("t6_nacks", ack_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < ack_log.size()) check($sformatf("t6_g%0d", i), ack_log[i], exp6[i]);
    repeat (6) begin neg(); tick(); end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
